// File: rtl/sar_search.sv
// Successive-approximation initiator: binary-searches a hidden comparator target
// by issuing query values and narrowing [lo, hi] from the l/e/g answers.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             req,
    output logic [WIDTH-1:0] query,
    input  logic             ack,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iters
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_QUERY  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Midpoint taken over WIDTH+1 bits so lo+hi cannot lose its carry.
    function automatic logic [WIDTH-1:0] mid_of(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[WIDTH:1];
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] lo_r, lo_s, hi_r, hi_s;
    logic [WIDTH-1:0] query_r, query_s, result_r, result_s, iters_r, iters_s;
    logic             req_r, req_s, busy_r, busy_s, done_r, done_s;
    logic             found_r, found_s, err_r, err_s;
    logic             stop_s, onehot_s;

    // Odd parity with not-all-three set is exactly one-hot for three bits.
    assign onehot_s = (l ^ e ^ g) & ~(l & e & g);

    // Next-state and next-output computation for the search FSM.
    always_comb begin
        state_s  = state_r;
        lo_s     = lo_r;
        hi_s     = hi_r;
        query_s  = query_r;
        req_s    = req_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        found_s  = found_r;
        err_s    = err_r;
        result_s = result_r;
        iters_s  = iters_r;
        stop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    lo_s     = ZERO;
                    hi_s     = ALL_ONES;
                    iters_s  = ZERO;
                    found_s  = 1'b0;
                    err_s    = 1'b0;
                    result_s = ZERO;
                    query_s  = mid_of(ZERO, ALL_ONES);
                    req_s    = 1'b1;
                    busy_s   = 1'b1;
                    state_s  = ST_QUERY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_QUERY: begin
                if (ack) begin
                    iters_s = iters_r + ONE;
                    if (!onehot_s) begin
                        err_s  = 1'b1;
                        stop_s = 1'b1;
                    end else if (e) begin
                        found_s  = 1'b1;
                        result_s = query_r;
                        stop_s   = 1'b1;
                    end else if (l) begin
                        if (query_r == ALL_ONES) begin
                            stop_s = 1'b1;
                        end else begin
                            lo_s = query_r + ONE;
                        end
                    end else begin
                        if (query_r == ZERO) begin
                            stop_s = 1'b1;
                        end else begin
                            hi_s = query_r - ONE;
                        end
                    end
                    // Range exhausted or answer conclusive: end the search next cycle.
                    if (stop_s || (lo_s > hi_s)) begin
                        req_s   = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_FINISH;
                    end else begin
                        query_s = mid_of(lo_s, hi_s);
                    end
                end else begin
                    state_s = ST_QUERY;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            lo_r     <= ZERO;
            hi_r     <= ALL_ONES;
            query_r  <= ZERO;
            req_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            found_r  <= 1'b0;
            err_r    <= 1'b0;
            result_r <= ZERO;
            iters_r  <= ZERO;
        end else begin
            state_r  <= state_s;
            lo_r     <= lo_s;
            hi_r     <= hi_s;
            query_r  <= query_s;
            req_r    <= req_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            found_r  <= found_s;
            err_r    <= err_s;
            result_r <= result_s;
            iters_r  <= iters_s;
        end
    end

    assign req    = req_r;
    assign query  = query_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign found  = found_r;
    assign err    = err_r;
    assign result = result_r;
    assign iters  = iters_r;

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a responder answers queries for a chosen target and the
// observed query sequence and final status are compared with a range-halving model.
module tb_sar_search;

    logic       clk, rst_n, start, req, ack, l, e, g;
    logic       busy, done, found, err;
    logic [3:0] query, result, iters;

    int total = 0;
    int bad   = 0;

    logic [31:0] obs_code, exp_code;
    logic [9:0]  obs_stat, exp_stat;
    bit          obs_timeout, obs_double;
    int          obs_unstable, obs_busybad, exp_n;
    bit          exp_found;

    sar_search #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .req(req), .query(query),
        .ack(ack), .l(l), .e(e), .g(g), .busy(busy), .done(done),
        .found(found), .err(err), .result(result), .iters(iters)
    );

    always #5 clk = ~clk;

    // Reference: halve the integer range [0,15] around the target until hit or empty.
    // Each query q is packed as 5 bits (q+1) so a whole sequence is one number.
    task automatic ref_model(input int t);
        int lo = 0;
        int hi = 15;
        int q;
        exp_code  = 32'd0;
        exp_n     = 0;
        exp_found = 1'b0;
        while (lo <= hi) begin
            q = (lo + hi) / 2;
            exp_code = (exp_code << 5) | (32'(q) + 32'd1);
            exp_n++;
            if (q == t) begin
                exp_found = 1'b1;
                break;
            end
            if (t > q) lo = q + 1;
            else hi = q - 1;
        end
    endtask

    // mode 0: honest comparator, 1: always less, 2: l and g, 3: no answer bit
    task automatic drive_answer(input int mode, input int t, input logic [3:0] q);
        case (mode)
            0: begin l = (int'(q) < t); e = (int'(q) == t); g = (int'(q) > t); end
            1: l = 1'b1;
            2: begin l = 1'b1; g = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic run_search(input int t, input int mode, input int delay, input bit extra);
        logic [3:0] q;
        bit done_seen;
        done_seen = 1'b0; obs_code = 32'd0; obs_stat = 10'd0; obs_timeout = 1'b0;
        obs_unstable = 0; obs_busybad = 0; obs_double = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                obs_stat  = {found, err, result, iters};
                if (req || busy) obs_busybad++;
                @(negedge clk);
                if (done) obs_double = 1'b1;
            end else if (req) begin
                q = query;
                obs_code = (obs_code << 5) | (32'(q) + 32'd1);
                if (!busy) obs_busybad++;
                for (int w = 0; w < delay; w++) begin
                    start = extra;
                    @(negedge clk);
                    start = 1'b0;
                    if (!req || query !== q) obs_unstable++;
                end
                ack = 1'b1;
                drive_answer(mode, t, q);
                @(negedge clk);
                ack = 1'b0; l = 1'b0; e = 1'b0; g = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!done_seen) obs_timeout = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if ({req, busy, done, found, err, query, result, iters} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {req, busy, done, found, err, query, result, iters});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_ignore_idle;
        int glitches = 0;
        ack = 1'b1; l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req || done || busy) glitches++;
        end
        ack = 1'b0; l = 1'b0;
        total++;
        if (glitches != 0) begin
            bad++;
            $display("FAIL idle_ignore: got %0d active cycles want 0", glitches);
        end
    endtask

    task automatic test_directed;
        int tgt[3]   = '{9, 0, 15};
        int n_exp[3] = '{3, 4, 5};
        for (int i = 0; i < 3; i++) begin
            ref_model(tgt[i]);
            run_search(tgt[i], 0, 0, 1'b0);
            exp_stat = {1'b1, 1'b0, 4'(tgt[i]), 4'(n_exp[i])};
            total++;
            if (obs_code !== exp_code) begin
                bad++;
                $display("FAIL directed_queries t=%0d: got %h want %h", tgt[i], obs_code, exp_code);
            end
            total++;
            if (obs_stat !== exp_stat) begin
                bad++;
                $display("FAIL directed_status t=%0d: got %h want %h", tgt[i], obs_stat, exp_stat);
            end
            total++;
            if (obs_timeout || obs_busybad != 0 || obs_double) begin
                bad++;
                $display("FAIL directed_protocol t=%0d: got timeout=%0d busy=%0d double=%0d want 0",
                         tgt[i], obs_timeout, obs_busybad, obs_double);
            end
        end
    endtask

    task automatic test_always_less;
        ref_model(16);
        run_search(0, 1, 0, 1'b0);
        total++;
        if (obs_code !== exp_code) begin
            bad++;
            $display("FAIL less_queries: got %h want %h", obs_code, exp_code);
        end
        total++;
        if (obs_stat !== {2'b00, 4'd0, 4'd5}) begin
            bad++;
            $display("FAIL less_status: got %h want %h", obs_stat, {2'b00, 4'd0, 4'd5});
        end
    endtask

    task automatic test_bad_answer;
        for (int m = 2; m <= 3; m++) begin
            run_search(0, m, 0, 1'b0);
            total++;
            if (obs_code !== 32'd8) begin
                bad++;
                $display("FAIL bad_answer_queries mode=%0d: got %h want 8", m, obs_code);
            end
            total++;
            if (obs_stat !== {1'b0, 1'b1, 4'd0, 4'd1} || obs_timeout) begin
                bad++;
                $display("FAIL bad_answer_status mode=%0d: got %h want %h", m, obs_stat, {1'b0, 1'b1, 4'd0, 4'd1});
            end
        end
    endtask

    task automatic test_random;
        int t, d;
        for (int i = 0; i < 20; i++) begin
            t = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 2));
            ref_model(t);
            run_search(t, 0, d, 1'b0);
            exp_stat = {exp_found, 1'b0, exp_found ? 4'(t) : 4'd0, 4'(exp_n)};
            total++;
            if (obs_code !== exp_code || obs_stat !== exp_stat) begin
                bad++;
                $display("FAIL random t=%0d d=%0d: got q=%h s=%h want q=%h s=%h",
                         t, d, obs_code, obs_stat, exp_code, exp_stat);
            end
            total++;
            if (obs_timeout || obs_unstable != 0 || obs_busybad != 0 || obs_double) begin
                bad++;
                $display("FAIL random_protocol t=%0d: got timeout=%0d unstable=%0d busy=%0d want 0",
                         t, obs_timeout, obs_unstable, obs_busybad);
            end
        end
    endtask

    task automatic test_delayed_ack;
        int dones = 0;
        ref_model(5);
        run_search(5, 0, 3, 1'b1);
        total++;
        if (obs_code !== exp_code || obs_stat !== {1'b1, 1'b0, 4'd5, 4'(exp_n)}) begin
            bad++;
            $display("FAIL delayed_result: got q=%h s=%h want q=%h s=%h",
                     obs_code, obs_stat, exp_code, {1'b1, 1'b0, 4'd5, 4'(exp_n)});
        end
        total++;
        if (obs_unstable != 0 || obs_timeout) begin
            bad++;
            $display("FAIL delayed_stable: got %0d unstable cycles want 0", obs_unstable);
        end
        // Second search, aborted by reset while the second query is outstanding.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ack = 1'b1; g = 1'b1;
        @(negedge clk); ack = 1'b0; g = 1'b0;
        total++;
        if (!(req && query == 4'd3)) begin
            bad++;
            $display("FAIL abort_second_query: got req=%0d query=%0d want req=1 query=3", req, query);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({req, busy, done, found, err, query, result, iters} !== 17'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %h want 0", {req, busy, done, found, err, query, result, iters});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || req || busy) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
        end
        ref_model(12);
        run_search(12, 0, 0, 1'b0);
        total++;
        if (obs_code !== exp_code || obs_stat !== {1'b1, 1'b0, 4'd12, 4'(exp_n)}) begin
            bad++;
            $display("FAIL after_abort: got q=%h s=%h want q=%h s=%h",
                     obs_code, obs_stat, exp_code, {1'b1, 1'b0, 4'd12, 4'(exp_n)});
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; start = 1'b0; ack = 1'b0;
        l = 1'b0; e = 1'b0; g = 1'b0;
        test_reset();
        test_ignore_idle();
        test_directed();
        test_always_less();
        test_bad_answer();
        test_random();
        test_delayed_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
